i2s_transceiver_gen: RTL

Parametrised I2S master transceiver, the next generation of the team's I2S receiver. It generates sclk and ws from mclk. It receives stereo samples on sd_rx and transmits stereo samples on sd_tx, in either standard I2S (one-bit delay) or left-justified format. It sits between the codec pins and the audio effects/FFT datapath, with one-cycle strobes marking frame-coherent data exchange.

---
 rtl/i2s_transceiver_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/i2s_transceiver_gen.sv
// I2S master transceiver: derives sclk/ws from mclk and moves one stereo frame
// in each direction per ws period, in standard I2S or left-justified framing.
module i2s_transceiver_gen #(
  parameter int SCLK_WS_RATIO   = 64,
  parameter int MCLK_SCLK_RATIO = 4,
  parameter int D_WIDTH         = 24,
  parameter int LJ_MODE         = 0
) (
  input  logic               mclk,
  input  logic               reset_n,
  output logic               sclk,
  output logic               ws,
  input  logic               sd_rx,
  output logic               sd_tx,
  input  logic [D_WIDTH-1:0] l_data_tx,
  input  logic [D_WIDTH-1:0] r_data_tx,
  output logic               tx_load,
  output logic [D_WIDTH-1:0] l_data_rx,
  output logic [D_WIDTH-1:0] r_data_rx,
  output logic               rx_valid
);

  localparam int H  = MCLK_SCLK_RATIO / 2;
  localparam int S  = SCLK_WS_RATIO / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int D  = (LJ_MODE != 0) ? 0 : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(H - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(S - 1);

  // One bit per slot of a half-frame, set where that slot carries sample data.
  function automatic logic [S-1:0] data_mask();
    logic [S-1:0] m;
    m = '0;
    for (int i = 0; i < S; i++)
      if (i >= D && i < D + D_WIDTH) m = m | (S'(1) << i);
    return m;
  endfunction

  localparam logic [S-1:0] DATA_MASK = data_mask();

  logic [CW-1:0]      mclk_cnt;
  logic [SW-1:0]      slot;
  logic [SW-1:0]      next_slot;
  logic [D_WIDTH-1:0] rx_l_sr, rx_r_sr, tx_l_sr, tx_r_sr;
  logic               half_wrap, sclk_rise, sclk_fall, frame_end;
  logic               next_ws, rx_data_slot, tx_data_slot;

  always_comb begin
    half_wrap    = (mclk_cnt == CNT_LAST);
    sclk_rise    = half_wrap && !sclk;
    sclk_fall    = half_wrap && sclk;
    frame_end    = sclk_fall && ws && (slot == SLOT_LAST);
    next_slot    = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
    next_ws      = (slot == SLOT_LAST) ? !ws : ws;
    rx_data_slot = DATA_MASK[slot];
    tx_data_slot = DATA_MASK[next_slot];
  end

  // sd_tx is driven for the slot being entered, so its choice uses next_slot/next_ws.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt  <= '0;
      slot      <= '0;
      sclk      <= 1'b0;
      ws        <= 1'b0;
      sd_tx     <= 1'b0;
      tx_load   <= 1'b0;
      rx_valid  <= 1'b0;
      l_data_rx <= '0;
      r_data_rx <= '0;
      rx_l_sr   <= '0;
      rx_r_sr   <= '0;
      tx_l_sr   <= '0;
      tx_r_sr   <= '0;
    end else begin
      tx_load  <= frame_end;
      rx_valid <= frame_end;
      mclk_cnt <= half_wrap ? '0 : mclk_cnt + CW'(1);
      if (half_wrap) sclk <= !sclk;

      if (sclk_rise && rx_data_slot) begin
        if (ws) rx_r_sr <= {rx_r_sr[D_WIDTH-2:0], sd_rx};
        else    rx_l_sr <= {rx_l_sr[D_WIDTH-2:0], sd_rx};
      end

      if (frame_end) begin
        l_data_rx <= rx_l_sr;
        r_data_rx <= rx_r_sr;
        tx_r_sr   <= r_data_tx;
      end

      if (sclk_fall) begin
        slot <= next_slot;
        ws   <= next_ws;
        if (!tx_data_slot) begin
          sd_tx <= 1'b0;
          if (frame_end) tx_l_sr <= l_data_tx;
        end else if (next_ws) begin
          sd_tx   <= tx_r_sr[D_WIDTH-1];
          tx_r_sr <= {tx_r_sr[D_WIDTH-2:0], 1'b0};
        end else if (frame_end) begin
          sd_tx   <= l_data_tx[D_WIDTH-1];
          tx_l_sr <= {l_data_tx[D_WIDTH-2:0], 1'b0};
        end else begin
          sd_tx   <= tx_l_sr[D_WIDTH-1];
          tx_l_sr <= {tx_l_sr[D_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule
